rz_decode: RTL and testbench



---
 rtl/ws2812_pkg.sv | 12 +
 rtl/rz_sync_edge.sv | 16 +
 rtl/rz_decode.sv | 102 ++++++++++
 tb/tb_rz_decode.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: WS2812 RZ line timing shared by the transmitter and the rz_decode receiver.
package ws2812_pkg;
   localparam int T_BIT        = 60;
   localparam int T0H          = 20;
   localparam int T1H          = 40;
   localparam int RESET_CYCLES = 2500;
   localparam int MIN_HIGH     = 8;
   localparam int THRESH_HIGH  = 30;
   localparam int MAX_HIGH     = 52;
   localparam int CNT_W        = 12;
   typedef enum logic {S_LOW, S_HIGH} state_t;
endpackage

// File: rtl/rz_sync_edge.sv
// rz_sync_edge: two-flop synchronizer plus delay flop with rise/fall strobes.
module rz_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic s,
   output logic rise,
   output logic fall
);
   logic m, s_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {m, s, s_d} <= '0;
      else        {m, s, s_d} <= {d, m, s};
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;
endmodule

// File: rtl/rz_decode.sv
// rz_decode: WS2812 RZ receiver; times high pulses into bits, packs 24-bit GRB words
// and flags the low-time latch gap that ends a frame.
module rz_decode #(
   parameter int MIN_HIGH     = ws2812_pkg::MIN_HIGH,
   parameter int THRESH_HIGH  = ws2812_pkg::THRESH_HIGH,
   parameter int MAX_HIGH     = ws2812_pkg::MAX_HIGH,
   parameter int RESET_CYCLES = ws2812_pkg::RESET_CYCLES,
   parameter int CNT_W        = ws2812_pkg::CNT_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rz_in,
   output logic [23:0] rgb,
   output logic        rgb_valid,
   output logic [15:0] pixel_idx,
   output logic        frame_end,
   output logic        bit_err
);
   import ws2812_pkg::*;
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HIGH);
   localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESH_HIGH);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HIGH);
   localparam logic [CNT_W-1:0] SAT_C = CNT_W'(MAX_HIGH + 1);
   localparam logic [CNT_W-1:0] RST_C = CNT_W'(RESET_CYCLES);
   logic             s, rise, fall;
   state_t           state;
   logic             gap_done;
   logic [CNT_W-1:0] hcnt, lcnt;
   logic [22:0]      sh;
   logic [4:0]       bit_cnt;
   logic [15:0]      word_cnt;
   logic             bit1, bit_ok;
   rz_sync_edge u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rz_in),
      .s    (s),
      .rise (rise),
      .fall (fall)
   );
   assign bit1   = hcnt > THR_C;
   assign bit_ok = hcnt >= MIN_C && hcnt <= MAX_C;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_LOW;
         gap_done  <= 1'b1;
         hcnt      <= '0;
         lcnt      <= '0;
         sh        <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         rgb       <= '0;
         rgb_valid <= 1'b0;
         pixel_idx <= '0;
         frame_end <= 1'b0;
         bit_err   <= 1'b0;
      end else begin
         rgb_valid <= 1'b0;
         frame_end <= 1'b0;
         bit_err   <= 1'b0;
         if (state == S_LOW) begin
            if (rise) begin
               hcnt  <= CNT_W'(1);
               lcnt  <= '0;
               state <= S_HIGH;
            end else begin
               if (lcnt != RST_C) lcnt <= lcnt + 1'b1;
               // gap_done keeps an idle line from latching the same frame twice
               if (lcnt == RST_C && !gap_done) begin
                  frame_end <= 1'b1;
                  gap_done  <= 1'b1;
                  bit_err   <= bit_cnt != 5'd0;
                  bit_cnt   <= '0;
                  pixel_idx <= '0;
                  word_cnt  <= '0;
               end
            end
         end else if (fall) begin
            lcnt     <= CNT_W'(1);
            gap_done <= 1'b0;
            state    <= S_LOW;
            if (!bit_ok) begin
               bit_err <= 1'b1;
               if (hcnt > MAX_C) bit_cnt <= '0;
            end else begin
               sh <= {sh[21:0], bit1};
               if (bit_cnt == 5'd23) begin
                  rgb       <= {sh, bit1};
                  rgb_valid <= 1'b1;
                  bit_cnt   <= '0;
                  pixel_idx <= word_cnt;
                  if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end else if (hcnt != SAT_C) begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rz_decode.sv
// tb_rz_decode: directed scenario bench for rz_decode, one task per feature.
module tb_rz_decode;
   logic        clk = 1'b0, rst_n = 1'b0, rz_in = 1'b0;
   logic [23:0] rgb;
   logic        rgb_valid, frame_end, bit_err;
   logic [15:0] pixel_idx;
   int n_cmp = 0, n_bad = 0;
   int cyc = 0, fall_cyc = 0, v_cyc = 0, fe_cyc = 0;
   int n_valid = 0, n_fe = 0, n_err = 0, n_fe_err = 0, n_clash = 0;
   logic [23:0] vq[$];
   logic [15:0] iq[$];
   logic [23:0] got_w;
   logic [15:0] got_i;

   rz_decode dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rz_in    (rz_in),
      .rgb      (rgb),
      .rgb_valid(rgb_valid),
      .pixel_idx(pixel_idx),
      .frame_end(frame_end),
      .bit_err  (bit_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rgb_valid) begin
         n_valid++;
         vq.push_back(rgb);
         iq.push_back(pixel_idx);
         v_cyc = cyc;
      end
      if (frame_end) begin
         n_fe++;
         fe_cyc = cyc;
      end
      if (bit_err) n_err++;
      if (frame_end && bit_err) n_fe_err++;
      if (rgb_valid && (bit_err || frame_end)) n_clash++;
   end

   task automatic pulse(input int high, input int period);
      rz_in = 1'b1;
      repeat (high) @(negedge clk);
      rz_in = 1'b0;
      fall_cyc = cyc;
      repeat (period - high) @(negedge clk);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) pulse(w[i] ? 40 : 20, 60);
   endtask

   task automatic gap();
      rz_in = 1'b0;
      repeat (2600) @(negedge clk);
   endtask

   task automatic clr();
      n_valid = 0; n_fe = 0; n_err = 0; n_fe_err = 0;
      vq.delete();
      iq.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++; if (rgb !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got %h want 000000", rgb); end
      n_cmp++; if (rgb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rgb_valid); end
      n_cmp++; if (pixel_idx !== 16'h0) begin n_bad++; $display("FAIL reset_idx got %h want 0000", pixel_idx); end
      n_cmp++; if (frame_end !== 1'b0) begin n_bad++; $display("FAIL reset_fe got %b want 0", frame_end); end
      n_cmp++; if (bit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", bit_err); end
      rst_n = 1'b1;
      clr();
      gap();
      n_cmp++; if (n_valid + n_fe + n_err != 0) begin n_bad++; $display("FAIL idle_after_reset got %0d pulses want 0", n_valid + n_fe + n_err); end
   endtask

   task automatic test_single_word();
      int fcyc;
      clr();
      send_bits(24'hA50FC3, 24);
      fcyc = fall_cyc;
      gap();
      got_w = vq.size() > 0 ? vq[0] : 24'hx;
      got_i = iq.size() > 0 ? iq[0] : 16'hx;
      n_cmp++; if (n_valid != 1) begin n_bad++; $display("FAIL single_nvalid got %0d want 1", n_valid); end
      n_cmp++; if (got_w !== 24'hA50FC3) begin n_bad++; $display("FAIL single_rgb got %h want a50fc3", got_w); end
      n_cmp++; if (got_i !== 16'h0) begin n_bad++; $display("FAIL single_idx got %h want 0000", got_i); end
      n_cmp++; if (v_cyc - fcyc != 3) begin n_bad++; $display("FAIL single_latency got %0d want 3", v_cyc - fcyc); end
      n_cmp++; if (n_fe != 1) begin n_bad++; $display("FAIL single_nfe got %0d want 1", n_fe); end
      n_cmp++; if (fe_cyc - fcyc < 2495 || fe_cyc - fcyc > 2510) begin n_bad++; $display("FAIL single_fe_delay got %0d want 2495..2510", fe_cyc - fcyc); end
      n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL single_err got %0d want 0", n_err); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] w[4];
      w = '{24'h111111, 24'h2C2C2C, 24'hFEDCBA, 24'h445566};
      clr();
      for (int i = 0; i < 3; i++) send_bits(w[i], 24);
      gap();
      n_cmp++; if (n_fe != 1) begin n_bad++; $display("FAIL b2b_nfe got %0d want 1", n_fe); end
      n_cmp++; if (pixel_idx !== 16'h0) begin n_bad++; $display("FAIL b2b_idx_after_gap got %h want 0000", pixel_idx); end
      send_bits(w[3], 24);
      gap();
      n_cmp++; if (n_valid != 4) begin n_bad++; $display("FAIL b2b_nvalid got %0d want 4", n_valid); end
      for (int i = 0; i < 4; i++) begin
         got_w = vq.size() > i ? vq[i] : 24'hx;
         got_i = iq.size() > i ? iq[i] : 16'hx;
         n_cmp++; if (got_w !== w[i]) begin n_bad++; $display("FAIL b2b_rgb%0d got %h want %h", i, got_w, w[i]); end
         n_cmp++; if (got_i !== 16'(i == 3 ? 0 : i)) begin n_bad++; $display("FAIL b2b_idx%0d got %0d want %0d", i, got_i, i == 3 ? 0 : i); end
      end
      n_cmp++; if (n_fe != 2 || n_err != 0) begin n_bad++; $display("FAIL b2b_fe_err got fe=%0d err=%0d want fe=2 err=0", n_fe, n_err); end
   endtask

   task automatic test_boundary();
      clr();
      for (int i = 0; i < 6; i++) begin
         pulse(8, 28); pulse(30, 50); pulse(31, 51); pulse(52, 72);
      end
      gap();
      got_w = vq.size() > 0 ? vq[0] : 24'hx;
      n_cmp++; if (n_valid != 1 || got_w !== 24'h333333) begin n_bad++; $display("FAIL bnd_widths got n=%0d rgb=%h want n=1 rgb=333333", n_valid, got_w); end
      n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL bnd_widths_err got %0d want 0", n_err); end
      clr();
      send_bits(24'h1F, 5);
      pulse(53, 73);
      send_bits(24'h5A5A5A, 24);
      gap();
      got_w = vq.size() > 0 ? vq[0] : 24'hx;
      n_cmp++; if (n_valid != 1 || got_w !== 24'h5A5A5A) begin n_bad++; $display("FAIL bnd_long got n=%0d rgb=%h want n=1 rgb=5a5a5a", n_valid, got_w); end
      n_cmp++; if (n_err != 1) begin n_bad++; $display("FAIL bnd_long_err got %0d want 1", n_err); end
      clr();
      send_bits(24'h15, 5);
      pulse(7, 27);
      send_bits(24'h0ABCD, 19);
      gap();
      got_w = vq.size() > 0 ? vq[0] : 24'hx;
      n_cmp++; if (n_valid != 1 || got_w !== 24'hA8ABCD) begin n_bad++; $display("FAIL bnd_glitch got n=%0d rgb=%h want n=1 rgb=a8abcd", n_valid, got_w); end
      n_cmp++; if (n_err != 1) begin n_bad++; $display("FAIL bnd_glitch_err got %0d want 1", n_err); end
   endtask

   task automatic test_partial();
      clr();
      send_bits(24'h2B5, 10);
      gap();
      n_cmp++; if (n_fe != 1 || n_fe_err != 1 || n_err != 1) begin n_bad++; $display("FAIL partial_pulses got fe=%0d both=%0d err=%0d want 1/1/1", n_fe, n_fe_err, n_err); end
      n_cmp++; if (n_valid != 0) begin n_bad++; $display("FAIL partial_nvalid got %0d want 0", n_valid); end
      n_cmp++; if (rgb !== 24'hA8ABCD) begin n_bad++; $display("FAIL partial_rgb_hold got %h want a8abcd", rgb); end
   endtask

   task automatic test_reset_mid();
      clr();
      send_bits(24'hABC, 12);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (rgb !== 24'h0 || pixel_idx !== 16'h0) begin n_bad++; $display("FAIL midrst_clear got rgb=%h idx=%h want 0", rgb, pixel_idx); end
      rst_n = 1'b1;
      @(negedge clk);
      clr();
      send_bits(24'h00FF00, 24);
      gap();
      got_w = vq.size() > 0 ? vq[0] : 24'hx;
      got_i = iq.size() > 0 ? iq[0] : 16'hx;
      n_cmp++; if (n_valid != 1 || got_w !== 24'h00FF00) begin n_bad++; $display("FAIL midrst_word got n=%0d rgb=%h want n=1 rgb=00ff00", n_valid, got_w); end
      n_cmp++; if (got_i !== 16'h0 || n_err != 0 || n_fe != 1) begin n_bad++; $display("FAIL midrst_misc got idx=%0d err=%0d fe=%0d want 0/0/1", got_i, n_err, n_fe); end
   endtask

   task automatic test_jitter();
      logic [23:0] exp_q[$];
      logic [23:0] w;
      int hi;
      clr();
      for (int k = 0; k < 30; k++) begin
         w = 24'($urandom);
         exp_q.push_back(w);
         for (int i = 23; i >= 0; i--) begin
            hi = (w[i] ? 40 : 20) + ($urandom_range(0, 1) != 0 ? 2 : -2);
            pulse(hi, int'($urandom_range(58, 62)));
         end
      end
      gap();
      n_cmp++; if (n_valid != 30 || n_err != 0) begin n_bad++; $display("FAIL jit_counts got n=%0d err=%0d want 30/0", n_valid, n_err); end
      for (int k = 0; k < 30; k++) begin
         got_w = vq.size() > k ? vq[k] : 24'hx;
         got_i = iq.size() > k ? iq[k] : 16'hx;
         n_cmp++; if (got_w !== exp_q[k] || got_i !== 16'(k)) begin n_bad++; $display("FAIL jit_word%0d got %h/%0d want %h/%0d", k, got_w, got_i, exp_q[k], k); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_boundary();
      test_partial();
      test_reset_mid();
      test_jitter();
      n_cmp++; if (n_clash != 0) begin n_bad++; $display("FAIL overlap got %0d want 0", n_clash); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
